// File: rtl/maze_wall_store.sv
// maze_wall_store: 4-bit-per-cell maze wall memory ({R,B,L,T}) with a
// self-clearing initialiser, a 1-cycle wall pixel renderer for the colour mux
// and N_QUERY round-robin lookup channels for collision logic.
// Optional feature macro: MAZE_BORDER_EN forces the outer border walls solid.
module maze_wall_store #(
    parameter int COLS      = 5,
    parameter int ROWS      = 7,
    parameter int CELL_LOG2 = 6,
    parameter int WALL_PX   = 2,
    parameter int N_QUERY   = 8,
    parameter int AW        = (COLS * ROWS > 1) ? $clog2(COLS * ROWS) : 1
) (
    input  logic                  Clk,
    input  logic                  Reset,
    input  logic                  clear_start,
    output logic                  busy,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [AW-1:0]         wr_addr,
    input  logic [3:0]            wr_data,
    input  logic [9:0]            DrawX,
    input  logic [9:0]            DrawY,
    output logic                  wall_pix,
    input  logic [N_QUERY-1:0]    q_req,
    input  logic [N_QUERY*10-1:0] q_x,
    input  logic [N_QUERY*10-1:0] q_y,
    output logic [N_QUERY-1:0]    q_ack,
    output logic [N_QUERY*4-1:0]  q_walls
);
    localparam int CELLS = COLS * ROWS;
    localparam int EDGE  = 1 << CELL_LOG2;
    localparam int PW    = (N_QUERY > 1) ? $clog2(N_QUERY) : 1;

    typedef enum logic {RESET_CLR, READY} state_t;

    state_t                     state, state_nxt;
    logic [AW-1:0]              clr_addr, clr_addr_nxt;
    logic [PW-1:0]              ptr;
    logic [3:0]                 mem [CELLS];

    logic [N_QUERY-1:0][9:0]    qx_v, qy_v;
    logic [N_QUERY-1:0][3:0]    walls_r;
    logic                       gnt_valid;
    logic [PW-1:0]              gnt_idx;
    logic [3:0]                 gnt_walls;
    logic [3:0]                 pix_walls;
    logic                       pix_hit;

    assign qx_v    = q_x;
    assign qy_v    = q_y;
    assign q_walls = walls_r;

    // Wall bits of the cell containing pixel (x,y); oob is returned off-grid.
    function automatic logic [3:0] read_cell(input logic [9:0] x, input logic [9:0] y,
                                             input logic [3:0] oob);
        int         col, row;
        logic [3:0] w;
        col = int'(x >> CELL_LOG2);
        row = int'(y >> CELL_LOG2);
        if (col >= COLS || row >= ROWS) return oob;
        w = mem[AW'(row * COLS + col)];
`ifdef MAZE_BORDER_EN
        if (row == 0)        w[0] = 1'b1;
        if (row == ROWS - 1) w[2] = 1'b1;
        if (col == 0)        w[1] = 1'b1;
        if (col == COLS - 1) w[3] = 1'b1;
`endif
        return w;
    endfunction

    // Clear FSM register; Reset always restarts the clear sweep from cell 0.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state    <= RESET_CLR;
            clr_addr <= '0;
        end else begin
            state    <= state_nxt;
            clr_addr <= clr_addr_nxt;
        end
    end

    // Clear FSM next state: one cell zeroed per cycle, clear_start restarts.
    always_comb begin
        state_nxt    = state;
        clr_addr_nxt = clr_addr;
        busy         = 1'b0;
        wr_ready     = 1'b0;
        case (state)
            RESET_CLR: begin
                busy = 1'b1;
                if (clear_start) begin
                    clr_addr_nxt = '0;
                end else if (clr_addr == AW'(CELLS - 1)) begin
                    state_nxt    = READY;
                    clr_addr_nxt = '0;
                end else begin
                    clr_addr_nxt = clr_addr + 1'b1;
                end
            end
            READY: begin
                wr_ready = 1'b1;
                if (clear_start) begin
                    state_nxt    = RESET_CLR;
                    clr_addr_nxt = '0;
                end
            end
            default: state_nxt = RESET_CLR;
        endcase
    end

    // Single write port: clearing owns it while busy; off-grid writes vanish.
    always_ff @(posedge Clk) begin
        if (state == RESET_CLR) begin
            mem[clr_addr] <= 4'h0;
        end else if (wr_valid && int'(wr_addr) < CELLS) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Wall stripe test for the current pixel; off-grid cells read as empty.
    always_comb begin
        int ox, oy;
        pix_walls = read_cell(DrawX, DrawY, 4'h0);
        ox        = int'(DrawX[CELL_LOG2-1:0]);
        oy        = int'(DrawY[CELL_LOG2-1:0]);
        pix_hit   = (pix_walls[3] && ox >= EDGE - WALL_PX) ||
                    (pix_walls[1] && ox <  WALL_PX)        ||
                    (pix_walls[2] && oy >= EDGE - WALL_PX) ||
                    (pix_walls[0] && oy <  WALL_PX);
    end

    // Registered pixel output, blanked while the memory is being cleared.
    always_ff @(posedge Clk) begin
        if (Reset) wall_pix <= 1'b0;
        else       wall_pix <= pix_hit && !busy;
    end

    // Round-robin pick: scan from ptr downward-overwrite so the first hit wins.
    always_comb begin
        logic [PW-1:0] scan;
        gnt_valid = 1'b0;
        gnt_idx   = '0;
        scan      = '0;
        for (int k = N_QUERY - 1; k >= 0; k--) begin
            scan = PW'((int'(ptr) + k) % N_QUERY);
            if (q_req[scan] && state == READY) begin
                gnt_valid = 1'b1;
                gnt_idx   = scan;
            end
        end
        gnt_walls = read_cell(qx_v[gnt_idx], qy_v[gnt_idx], 4'hF);
    end

    // Lookup response: one-cycle ack, result held until that channel's next ack.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            ptr     <= '0;
            q_ack   <= '0;
            walls_r <= '0;
        end else begin
            q_ack <= '0;
            if (gnt_valid) begin
                q_ack[gnt_idx]   <= 1'b1;
                walls_r[gnt_idx] <= gnt_walls;
                ptr              <= PW'((int'(gnt_idx) + 1) % N_QUERY);
            end
        end
    end
endmodule

// File: doc/maze_wall_store.md
# maze_wall_store

Parametrised maze wall memory with a synchronous write port, a self-clearing initialiser, a pipelined per-pixel wall renderer and N arbitrated collision-lookup channels. Each cell stores four wall bits. The pixel path drives the VGA colour mux. The lookup channels serve bullet and tank collision logic, replacing per-object combinational reads with a round-robin, request/acknowledge interface.

## Interface
- COLS, 5, cells per row (1..32)
- ROWS, 7, cells per column (1..32)
- CELL_LOG2, 6, log2 of cell edge in pixels (cell = 64 px)
- WALL_PX, 2, wall stripe thickness in pixels on each cell edge (1..2^(CELL_LOG2-1))
- N_QUERY, 8, number of lookup channels (1..16)
- AW, derived $clog2(COLS*ROWS), cell address width
- Clk  in  1  system clock
- Reset  in  1  synchronous, active-high reset
- clear_start  in  1  pulse: re-run the clear sequence
- busy  out  1  high while clearing
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted when wr_valid & wr_ready
- wr_addr  in  AW  cell index = row*COLS + col
- wr_data  in  4  wall bits {R,B,L,T} = bits [3:0]
- DrawX, DrawY  in  10 each  current pixel
- wall_pix  out  1  pixel lies on a present wall stripe
- q_req  in  N_QUERY  per-channel lookup request, held until ack
- q_x, q_y  in  N_QUERY*10 each  flattened query pixel coordinates, channel i at [10i+:10]
- q_ack  out  N_QUERY  one-cycle acknowledge
- q_walls  out  N_QUERY*4  flattened result, channel i at [4i+:4], held until next ack on that channel

## Operation
- Storage: COLS*ROWS entries of 4 bits. Out-of-range wr_addr (≥ COLS*ROWS) is accepted and discarded.
- Clear FSM states:
  - RESET_CLR: entered on Reset. Writes 0 to one address per cycle, starting at 0.
  - READY: entered after the write to address COLS*ROWS-1.
  - clear_start in READY → RESET_CLR from address 0.
  - clear_start during RESET_CLR restarts at address 0.
  - busy=1 and wr_ready=0 in RESET_CLR. No grants are issued while busy.
- Write: in READY, wr_ready=1 and accepted data is written at the clock edge.
- Pixel path:
  - col = DrawX>>CELL_LOG2, row = DrawY>>CELL_LOG2, ox = DrawX[CELL_LOG2-1:0], oy likewise, E = 2^CELL_LOG2.
  - Hit = (R & ox≥E-WALL_PX) | (L & ox<WALL_PX) | (B & oy≥E-WALL_PX) | (T & oy<WALL_PX).
  - col≥COLS or row≥ROWS → hit=0. Forced 0 while busy.
- Lookup:
  - Round-robin arbiter grants at most one requesting channel per cycle.
  - Search starts at the channel after the last granted; after reset the pointer starts at channel 0.
  - Granted cell = (q_y>>CELL_LOG2)*COLS + (q_x>>CELL_LOG2). A coordinate outside the grid returns 4'hF (solid).
  - A channel is never granted twice for one request: after ack, the requester must drop q_req for at least one cycle or present a new request.
  - Maximum wait: N_QUERY cycles.
- Same-cycle write and lookup/pixel read of the same cell returns the old value (read-before-write).

## Timing
- Reset values: busy=1, wr_ready=0, wall_pix=0, q_ack=0, q_walls=0, arbiter pointer=0, clear address=0.
- Clear duration: exactly COLS*ROWS cycles after Reset deasserts; busy falls on the next edge.
- wall_pix: 1-cycle latency from DrawX/DrawY.
- Lookup: grant at edge k; q_ack[i]=1 and q_walls valid at edge k+1 (latency 1). q_ack lasts exactly 1 cycle.
- A write accepted at edge k is visible to pixel and lookup reads sampled at edge k+1.
- Reset mid-clear or mid-lookup: pending grants are dropped, no ack is issued, and the FSM restarts the clear.

## Configuration
- MAZE_BORDER_EN:
  - Defined: the outer border is always solid, regardless of stored bits. T is forced on row 0, B on row ROWS-1, L on col 0 and R on col COLS-1, for both the pixel path and lookups.
  - Undefined: only stored bits are used.

## Test plan
- Reset, default parameters → busy high for 35 cycles; all 35 cells read 0 and wall_pix=0 across the frame.
- Write addr 0 = 4'b1001; DrawX=63,DrawY=10 → wall_pix=1 one cycle later; DrawX=30,DrawY=30 → wall_pix=0.
- All 8 channels request simultaneously at cell 0 → eight acks on eight consecutive cycles in order 0..7, each with q_walls=4'b1001.
- q_x=700 on channel 3 → q_walls[15:12]=4'hF after 1 cycle.
- Write cell 6 = 4'h4 in the same cycle as a channel-0 lookup of cell 6 → ack returns old 0; the next lookup returns 4'h4.
- With MAZE_BORDER_EN, empty maze, DrawX=0,DrawY=100 → wall_pix=1; without it → 0.
